wr_mem_mc: RTL and testbench

- Parametrised multi-channel DRAM write engine. Successor to the single-input video write engine.
- Arbitrates round-robin among NCH first-word-fall-through (FWFT) video line FIFOs.
- Moves one BL-word burst from the granted channel into the memory-controller write port, then issues one write command.
- Address per burst is {channel, line, segment}. Sits between the video_mix input FIFOs and one MCB write port.

---
 rtl/wr_mem_mc_if.sv | 29 ++
 rtl/wr_mem_mc.sv | 203 ++++++++++++++++++++
 tb/tb_wr_mem_mc.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_mem_mc_if.sv
// Memory-controller write port: command channel plus write-data FIFO.
// The engine drives it through the master modport; the controller model or
// the real controller sits on the slave side.
interface wr_mem_mc_if #(
   parameter int DW = 128
);
   logic          cmd_en;
   logic [2:0]    cmd_instr;
   logic [5:0]    cmd_bl;
   logic [29:0]   cmd_byte_addr;
   logic          cmd_full;
   logic          wr_en;
   logic [DW/8-1:0] wr_mask;
   logic [DW-1:0] wr_data;
   logic          wr_full;
   logic [6:0]    wr_count;

   modport master (
      output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
      output wr_en, wr_mask, wr_data,
      input  cmd_full, wr_full, wr_count
   );

   modport slave (
      input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
      input  wr_en, wr_mask, wr_data,
      output cmd_full, wr_full, wr_count
   );
endinterface

// File: rtl/wr_mem_mc.sv
// Multi-channel DRAM write engine. Picks one of NCH FWFT line FIFOs in
// round-robin order, streams one BL-word burst into the controller write
// FIFO, then issues a single write command addressed {channel, line, segment}.
module wr_mem_mc #(
   parameter int DW     = 128,
   parameter int BL     = 64,
   parameter int NCH    = 2,
   parameter int CH_W   = 1,
   parameter int LINE_W = 11,
   parameter int SEG_W  = 1,
   parameter int COL_W  = 13,
   parameter int CNT_W  = 7
) (
   input  logic                    cmd_clk,
   input  logic                    rst_n,
   input  logic                    calib_done,
   wr_mem_mc_if.master             mcb,
   input  logic                    arb_ok,
   input  logic [NCH-1:0]          ch_en,
   input  logic [NCH*DW-1:0]       ch_data,
   input  logic [NCH-1:0]          ch_empty,
   input  logic [NCH*CNT_W-1:0]    ch_count,
   input  logic [NCH*LINE_W-1:0]   ch_line,
   input  logic [NCH*SEG_W-1:0]    ch_seg,
   output logic [NCH-1:0]          ch_rd_en,
   output logic [NCH-1:0]          done,
   output logic                    busy,
   output logic [7:0]              debug
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WRD  = 2'd1,
      CMD  = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam int CW          = $clog2(BL + 1);
   localparam int BURST_BYTES = BL * DW / 8;

   state_t             state;
   logic [1:0]         state_bits;
   logic [CH_W-1:0]    grant;
   logic [CH_W-1:0]    rr_ptr;
   logic [LINE_W-1:0]  line_q;
   logic [SEG_W-1:0]   seg_q;
   logic [CW-1:0]      wr_cnt;
   logic               cmd_en_q;
   logic [29:0]        addr_q;
   logic [NCH-1:0]     done_q;

   logic [NCH-1:0]     eligible;
   logic               found;
   logic [CH_W-1:0]    pick;
   logic [LINE_W-1:0]  pick_line;
   logic [SEG_W-1:0]   pick_seg;
   logic [DW-1:0]      sel_data;
   logic               sel_empty;
   logic               push;
   logic [COL_W-1:0]   col;

   // A channel may be granted only when enabled and holding a full burst.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NCH; i++) begin
         eligible[i] = ch_en[i] && (int'(ch_count[i*CNT_W +: CNT_W]) >= BL);
      end
   end

   // Round-robin search starting at rr_ptr; the first eligible hit wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NCH; k++) begin
         for (int i = 0; i < NCH; i++) begin
            if (!found && (i == (int'(rr_ptr) + k) % NCH) && eligible[i]) begin
               found = 1'b1;
               pick  = CH_W'(i);
            end
         end
      end
   end

   // Head-burst line and segment of the candidate channel, latched on grant.
   always_comb begin
      pick_line = '0;
      pick_seg  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (int'(pick) == i) begin
            pick_line = ch_line[i*LINE_W +: LINE_W];
            pick_seg  = ch_seg[i*SEG_W +: SEG_W];
         end
      end
   end

   // Data and empty flag of the currently granted channel.
   always_comb begin
      sel_data  = '0;
      sel_empty = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (int'(grant) == i) begin
            sel_data  = ch_data[i*DW +: DW];
            sel_empty = ch_empty[i];
         end
      end
   end

   // A word moves only while bursting, with source data present and sink room.
   always_comb begin
      push = (state == WRD) && calib_done && !sel_empty && !mcb.wr_full &&
             (int'(wr_cnt) < BL);
   end

   // Pop only the granted channel, in lockstep with the write-FIFO push.
   always_comb begin
      ch_rd_en = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_rd_en[i] = push && (int'(grant) == i);
      end
   end

   // Byte column of the burst within the line: segment times burst size.
   always_comb begin
      col = COL_W'(int'(seg_q) * BURST_BYTES);
   end

   // Burst sequencer: grant, stream words, wait for command slot, one idle gap.
   always_ff @(posedge cmd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         line_q   <= '0;
         seg_q    <= '0;
         wr_cnt   <= '0;
         cmd_en_q <= 1'b0;
         addr_q   <= '0;
         done_q   <= '0;
      end else if (!calib_done) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         line_q   <= '0;
         seg_q    <= '0;
         wr_cnt   <= '0;
         cmd_en_q <= 1'b0;
         addr_q   <= '0;
         done_q   <= '0;
      end else begin
         cmd_en_q <= 1'b0;
         done_q   <= '0;
         case (state)
            IDLE: begin
               if (found && (mcb.wr_count == 7'd0)) begin
                  grant  <= pick;
                  line_q <= pick_line;
                  seg_q  <= pick_seg;
                  wr_cnt <= '0;
                  state  <= WRD;
               end
            end
            WRD: begin
               if (push) begin
                  wr_cnt <= wr_cnt + CW'(1);
               end
               if (int'(wr_cnt) == BL) begin
                  state <= CMD;
               end
            end
            CMD: begin
               if (!mcb.cmd_full && arb_ok && (int'(mcb.wr_count) >= BL)) begin
                  cmd_en_q <= 1'b1;
                  addr_q   <= 30'({grant, line_q, col});
                  for (int i = 0; i < NCH; i++) begin
                     done_q[i] <= (int'(grant) == i);
                  end
                  rr_ptr   <= (int'(grant) == NCH - 1) ? '0 : grant + CH_W'(1);
                  state    <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign state_bits        = state;
   assign mcb.cmd_en        = cmd_en_q;
   assign mcb.cmd_instr     = 3'd2;
   assign mcb.cmd_bl        = 6'(BL - 1);
   assign mcb.cmd_byte_addr = addr_q;
   assign mcb.wr_en         = push;
   assign mcb.wr_mask       = '0;
   assign mcb.wr_data       = sel_data;
   assign done              = done_q;
   assign busy              = (state != IDLE);
   assign debug             = {3'(grant), mcb.wr_full, mcb.cmd_full, push, state_bits};

endmodule

// File: tb/tb_wr_mem_mc.sv
// Directed bench for wr_mem_mc: two channels, FIFO and controller models,
// hand-computed addresses and word counts for each scenario.
module tb_wr_mem_mc;

   localparam int DW = 128;

   logic            cmd_clk = 1'b0;
   logic            rst_n;
   logic            calib_done;
   logic            arb_ok;
   logic [1:0]      ch_en;
   logic [2*DW-1:0] ch_data;
   logic [1:0]      ch_empty;
   logic [13:0]     ch_count;
   logic [21:0]     ch_line;
   logic [1:0]      ch_seg;
   logic [1:0]      ch_rd_en;
   logic [1:0]      done;
   logic            busy;
   logic [7:0]      debug;

   int checks   = 0;
   int failures = 0;

   int head_seq[2] = '{0, 0};
   int push_cnt[2] = '{0, 0};
   int done_cnt[2] = '{0, 0};
   int cmd_cnt     = 0;

   logic        s_push = 1'b0;
   int          s_ch   = 0;
   logic        s_cmd  = 1'b0;
   logic [1:0]  s_done = 2'b00;
   logic        prev_cmd = 1'b0;

   wr_mem_mc_if #(.DW(DW)) mcb ();

   wr_mem_mc #(
      .DW(DW), .BL(64), .NCH(2), .CH_W(1), .LINE_W(11),
      .SEG_W(1), .COL_W(13), .CNT_W(7)
   ) dut (
      .cmd_clk    (cmd_clk),
      .rst_n      (rst_n),
      .calib_done (calib_done),
      .mcb        (mcb),
      .arb_ok     (arb_ok),
      .ch_en      (ch_en),
      .ch_data    (ch_data),
      .ch_empty   (ch_empty),
      .ch_count   (ch_count),
      .ch_line    (ch_line),
      .ch_seg     (ch_seg),
      .ch_rd_en   (ch_rd_en),
      .done       (done),
      .busy       (busy),
      .debug      (debug)
   );

   always #5 cmd_clk = ~cmd_clk;

   function automatic logic [127:0] make_word(input int ch, input int seq);
      return {ch[7:0], 88'd0, seq[31:0]};
   endfunction

   assign ch_data = {make_word(1, head_seq[1]), make_word(0, head_seq[0])};

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Mid-cycle monitor: data order, pop/push pairing, command spacing.
   always @(negedge cmd_clk) begin
      #2;
      if (mcb.wr_en || (ch_rd_en != 2'b00)) begin
         check_output("pop_push_align",
                      128'({mcb.wr_en, ($countones(ch_rd_en) == 1)}), 128'(3));
         check_output("wr_data_order", mcb.wr_data,
                      make_word(ch_rd_en[1] ? 1 : 0, head_seq[ch_rd_en[1] ? 1 : 0]));
      end
      if (mcb.cmd_en) check_output("cmd_back_to_back", 128'(prev_cmd), 128'(0));
      if (done != 2'b00) check_output("done_with_cmd", 128'(mcb.cmd_en), 128'(1));
      s_push   <= mcb.wr_en;
      s_ch     <= ch_rd_en[1] ? 1 : 0;
      s_cmd    <= mcb.cmd_en;
      s_done   <= done;
      prev_cmd <= mcb.cmd_en;
   end

   // FIFO and controller models: advance heads, count words, drain on command.
   always @(posedge cmd_clk or negedge rst_n) begin
      if (!rst_n) begin
         mcb.wr_count <= 7'd0;
      end else begin
         if (s_push) begin
            head_seq[s_ch] <= head_seq[s_ch] + 1;
            push_cnt[s_ch] <= push_cnt[s_ch] + 1;
            mcb.wr_count   <= mcb.wr_count + 7'd1;
         end
         if (s_cmd) begin
            cmd_cnt      <= cmd_cnt + 1;
            mcb.wr_count <= 7'd0;
         end
         for (int i = 0; i < 2; i++) begin
            if (s_done[i]) done_cnt[i] <= done_cnt[i] + 1;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge cmd_clk);
   endtask

   task automatic wait_push(input int ch, input int target, input string tag);
      int t = 0;
      while (push_cnt[ch] != target && t < 400) begin
         @(negedge cmd_clk);
         t++;
      end
      check_output(tag, 128'(push_cnt[ch]), 128'(target));
   endtask

   task automatic wait_cmd(input string tag);
      int t = 0;
      while (!mcb.cmd_en && t < 600) begin
         @(negedge cmd_clk);
         t++;
      end
      check_output(tag, 128'(mcb.cmd_en), 128'(1));
   endtask

   task automatic wait_wr_en(input string tag);
      int t = 0;
      while (!mcb.wr_en && t < 20) begin
         @(negedge cmd_clk);
         t++;
      end
      check_output(tag, 128'(mcb.wr_en), 128'(1));
   endtask

   initial begin
      rst_n        = 1'b0;
      calib_done   = 1'b0;
      arb_ok       = 1'b1;
      mcb.cmd_full = 1'b0;
      mcb.wr_full  = 1'b0;
      ch_en        = 2'b00;
      ch_empty     = 2'b00;
      ch_count     = '0;
      ch_line      = '0;
      ch_seg       = '0;
      cycles(3);

      // Reset values and constant outputs
      check_output("reset_cmd_en",   128'(mcb.cmd_en), 128'(0));
      check_output("reset_wr_en",    128'(mcb.wr_en), 128'(0));
      check_output("reset_rd_en",    128'(ch_rd_en), 128'(0));
      check_output("reset_done",     128'(done), 128'(0));
      check_output("reset_busy",     128'(busy), 128'(0));
      check_output("reset_addr",     128'(mcb.cmd_byte_addr), 128'(0));
      check_output("reset_debug",    128'(debug), 128'(0));
      check_output("const_instr",    128'(mcb.cmd_instr), 128'(2));
      check_output("const_bl",       128'(mcb.cmd_bl), 128'(63));
      check_output("const_mask",     128'(mcb.wr_mask), 128'(0));

      // Calibration not done holds the engine idle
      rst_n         = 1'b1;
      ch_count[6:0] = 7'd64;
      ch_en         = 2'b01;
      cycles(5);
      check_output("calib_hold_busy", 128'(busy), 128'(0));
      check_output("calib_hold_wr",   128'(mcb.wr_en), 128'(0));

      // One word short of a burst is not eligible
      calib_done    = 1'b1;
      ch_count[6:0] = 7'd63;
      cycles(5);
      check_output("count63_no_grant", 128'(busy), 128'(0));

      // Single burst from channel 0, line 5, segment 1
      $display("[TB] single burst ch0");
      ch_line[10:0] = 11'd5;
      ch_seg[0]     = 1'b1;
      ch_count[6:0] = 7'd64;
      wait_wr_en("a_first_push");
      check_output("a_debug_wrd", 128'(debug), 128'(8'h05));
      wait_cmd("a_cmd_seen");
      check_output("a_addr", 128'(mcb.cmd_byte_addr), 128'(30'd41984));
      check_output("a_done", 128'(done), 128'(2'b01));
      check_output("a_push_ch0", 128'(push_cnt[0]), 128'(64));
      check_output("a_push_ch1", 128'(push_cnt[1]), 128'(0));
      ch_en = 2'b00;
      cycles(1);
      check_output("a_gap_cmd_low", 128'(mcb.cmd_en), 128'(0));
      check_output("a_done_pulse", 128'(done), 128'(0));
      cycles(3);
      check_output("a_cmd_count", 128'(cmd_cnt), 128'(1));
      check_output("a_done_count", 128'(done_cnt[0]), 128'(1));
      check_output("a_idle", 128'(busy), 128'(0));

      // Both channels eligible: grants alternate starting after channel 0
      $display("[TB] round robin");
      ch_line  = {11'd7, 11'd3};
      ch_seg   = 2'b00;
      ch_count = {7'd64, 7'd64};
      ch_en    = 2'b11;
      for (int n = 0; n < 4; n++) begin
         wait_cmd("b_cmd_seen");
         check_output("b_addr", 128'(mcb.cmd_byte_addr),
                      128'((n % 2 == 0) ? 30'd16834560 : 30'd24576));
         if (n == 3) ch_en = 2'b00;
         cycles(1);
      end
      cycles(3);
      check_output("b_push_ch0", 128'(push_cnt[0]), 128'(192));
      check_output("b_push_ch1", 128'(push_cnt[1]), 128'(128));
      check_output("b_done_ch0", 128'(done_cnt[0]), 128'(3));
      check_output("b_done_ch1", 128'(done_cnt[1]), 128'(2));
      check_output("b_cmd_count", 128'(cmd_cnt), 128'(5));

      // Channel 0 runs dry for 5 cycles at word 10
      $display("[TB] empty stall");
      ch_line[10:0] = 11'd9;
      ch_en         = 2'b01;
      wait_push(0, 202, "c_reach_word10");
      ch_empty[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_output("c_empty_no_push", 128'(mcb.wr_en), 128'(0));
         @(negedge cmd_clk);
      end
      ch_empty[0] = 1'b0;
      check_output("c_words_held", 128'(push_cnt[0]), 128'(202));
      wait_cmd("c_cmd_seen");
      check_output("c_addr", 128'(mcb.cmd_byte_addr), 128'(30'd73728));
      check_output("c_push_total", 128'(push_cnt[0]), 128'(256));
      ch_en = 2'b00;
      cycles(3);

      // Write FIFO full for 3 cycles at word 20
      $display("[TB] wr_full stall");
      ch_line[10:0] = 11'd2;
      ch_seg[0]     = 1'b1;
      ch_en         = 2'b01;
      wait_push(0, 276, "d_reach_word20");
      mcb.wr_full = 1'b1;
      #1;
      check_output("d_debug_full", 128'(debug), 128'(8'h11));
      for (int i = 0; i < 3; i++) begin
         #1;
         check_output("d_full_no_push", 128'({mcb.wr_en, ch_rd_en}), 128'(0));
         @(negedge cmd_clk);
      end
      mcb.wr_full = 1'b0;
      check_output("d_words_held", 128'(push_cnt[0]), 128'(276));
      wait_cmd("d_cmd_seen");
      check_output("d_addr", 128'(mcb.cmd_byte_addr), 128'(30'd17408));
      check_output("d_push_total", 128'(push_cnt[0]), 128'(320));
      ch_en = 2'b00;
      cycles(3);

      // Command FIFO full and arbiter denial hold the command
      $display("[TB] command hold-off");
      mcb.cmd_full  = 1'b1;
      arb_ok        = 1'b0;
      ch_line[10:0] = 11'd4;
      ch_seg[0]     = 1'b0;
      ch_en         = 2'b01;
      wait_push(0, 384, "e_burst_full");
      cycles(3);
      for (int i = 0; i < 4; i++) begin
         check_output("e_blocked_cmd", 128'(mcb.cmd_en), 128'(0));
         @(negedge cmd_clk);
      end
      check_output("e_debug_cmd", 128'(debug), 128'(8'h0A));
      mcb.cmd_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge cmd_clk);
         check_output("e_arb_denied", 128'(mcb.cmd_en), 128'(0));
      end
      check_output("e_no_cmd_yet", 128'(cmd_cnt), 128'(7));
      arb_ok = 1'b1;
      wait_cmd("e_cmd_seen");
      check_output("e_addr", 128'(mcb.cmd_byte_addr), 128'(30'd32768));
      ch_en = 2'b00;
      cycles(1);
      check_output("e_gap_cmd_low", 128'(mcb.cmd_en), 128'(0));
      cycles(3);
      check_output("e_cmd_count", 128'(cmd_cnt), 128'(8));

      // Asynchronous reset at word 30 abandons the burst without a command
      $display("[TB] reset mid-burst");
      ch_line[10:0] = 11'd6;
      ch_en         = 2'b01;
      wait_push(0, 414, "f_reach_word30");
      #1;
      rst_n = 1'b0;
      #1;
      check_output("f_async_wr_en", 128'(mcb.wr_en), 128'(0));
      check_output("f_async_rd_en", 128'(ch_rd_en), 128'(0));
      check_output("f_async_busy",  128'(busy), 128'(0));
      check_output("f_async_addr",  128'(mcb.cmd_byte_addr), 128'(0));
      ch_en = 2'b00;
      cycles(2);
      rst_n = 1'b1;
      cycles(20);
      check_output("f_no_cmd", 128'(cmd_cnt), 128'(8));
      check_output("f_no_push", 128'(push_cnt[0]), 128'(414));

      // A fresh full burst after reset gets the only command
      ch_en = 2'b01;
      wait_cmd("f_cmd_seen");
      check_output("f_addr", 128'(mcb.cmd_byte_addr), 128'(30'd49152));
      check_output("f_push_total", 128'(push_cnt[0]), 128'(478));
      ch_en = 2'b00;
      cycles(3);
      check_output("f_cmd_count", 128'(cmd_cnt), 128'(9));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
